// File: rtl/lm_sm_sequencer_if.sv
// rtl/lm_sm_sequencer_if.sv - IF/ID-side handshake bundle between pipeline and LM/SM sequencer
interface lm_sm_sequencer_if;
    logic [15:0] id_ir;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic        pc_write;
    logic        ir_load_mux;
    logic [15:0] new_ir_multi;
    logic        first_multiple;
    logic        last_multiple;
    logic        busy;
    logic        zero_mask_flush;

    // Pipeline / hazard-unit side: presents the instruction and hold/abort controls
    modport master (
        output id_ir,
        output id_valid,
        output stall,
        output flush,
        input  pc_write,
        input  ir_load_mux,
        input  new_ir_multi,
        input  first_multiple,
        input  last_multiple,
        input  busy,
        input  zero_mask_flush
    );

    // Sequencer side
    modport slave (
        input  id_ir,
        input  id_valid,
        input  stall,
        input  flush,
        output pc_write,
        output ir_load_mux,
        output new_ir_multi,
        output first_multiple,
        output last_multiple,
        output busy,
        output zero_mask_flush
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM expander into single-register micro-ops (optional LCA_LM_BASE_LAST_EN)
module lm_sm_sequencer (
    input  logic             clk,
    input  logic             reset,
    lm_sm_sequencer_if.slave bus
);
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  mask;
    logic [3:0]  op_q;
    logic [2:0]  ra_q;
`ifdef LCA_LM_BASE_LAST_EN
    logic [7:0]  orig_mask;
`else
    logic [2:0]  offset;
`endif

    logic        ir_load_mux_q;
    logic [15:0] new_ir_multi_q;
    logic        first_q;
    logic        last_q;
    logic        busy_q;
    logic        zmf_q;

    logic        is_lm_sm;
    logic        detect;
    logic [7:0]  src_mask;
    logic [3:0]  src_op;
    logic [2:0]  src_ra;
    logic [7:0]  ra_bit;
    logic [7:0]  walk_mask;
    logic [2:0]  sel_idx;
    logic [7:0]  rem_mask;
    logic [2:0]  sel_off;
    logic [15:0] uop;
`ifdef LCA_LM_BASE_LAST_EN
    logic [7:0]  base_mask;
`endif

    // Bit 8 of an LM/SM word carries no meaning for the sequencer
    logic unused_ir_bit;
    assign unused_ir_bit = bus.id_ir[8];

    assign is_lm_sm = (bus.id_ir[15:12] == OP_LM) || (bus.id_ir[15:12] == OP_SM);
    assign detect   = bus.id_valid && is_lm_sm && (state == S_IDLE) && !bus.flush;

    // Pick the next register from either the incoming word (first micro-op) or the latched remainder
    always_comb begin
        src_mask = mask;
        src_op   = op_q;
        src_ra   = ra_q;
`ifdef LCA_LM_BASE_LAST_EN
        base_mask = orig_mask;
`endif
        if (state == S_IDLE) begin
            src_mask = bus.id_ir[7:0];
            src_op   = bus.id_ir[15:12];
            src_ra   = bus.id_ir[11:9];
`ifdef LCA_LM_BASE_LAST_EN
            base_mask = bus.id_ir[7:0];
`endif
        end

        ra_bit    = 8'b1 << src_ra;
        walk_mask = src_mask;
`ifdef LCA_LM_BASE_LAST_EN
        // Loading the base register early would corrupt later addresses, so hold it back until alone
        if ((src_op == OP_LM) && ((src_mask & ra_bit) != 8'h00) && ((src_mask & ~ra_bit) != 8'h00)) begin
            walk_mask = src_mask & ~ra_bit;
        end
`endif

        sel_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (walk_mask[k]) begin
                sel_idx = 3'(k);
            end
        end
        rem_mask = src_mask & ~(8'b1 << sel_idx);

`ifdef LCA_LM_BASE_LAST_EN
        // Offset is the register's rank in the original mask, independent of issue order
        sel_off = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if ((k < int'(sel_idx)) && base_mask[k]) begin
                sel_off = sel_off + 3'd1;
            end
        end
`else
        sel_off = (state == S_IDLE) ? 3'd0 : offset;
`endif

        uop = {src_op, src_ra, sel_idx, 3'b000, sel_off};
    end

    // Sequencer FSM: flush beats stall beats normal progress; all outputs registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            mask           <= 8'h00;
            op_q           <= 4'h0;
            ra_q           <= 3'd0;
`ifdef LCA_LM_BASE_LAST_EN
            orig_mask      <= 8'h00;
`else
            offset         <= 3'd0;
`endif
            ir_load_mux_q  <= 1'b0;
            new_ir_multi_q <= 16'h0000;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            busy_q         <= 1'b0;
            zmf_q          <= 1'b0;
        end else if (bus.flush) begin
            state         <= S_IDLE;
            mask          <= 8'h00;
`ifndef LCA_LM_BASE_LAST_EN
            offset        <= 3'd0;
`endif
            ir_load_mux_q <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            zmf_q         <= 1'b0;
        end else if (!bus.stall) begin
            case (state)
                S_IDLE: begin
                    ir_load_mux_q <= 1'b0;
                    first_q       <= 1'b0;
                    last_q        <= 1'b0;
                    busy_q        <= 1'b0;
                    zmf_q         <= 1'b0;
                    if (detect) begin
                        if (bus.id_ir[7:0] == 8'h00) begin
                            zmf_q <= 1'b1;
                        end else begin
                            // First micro-op goes out on the accepting edge itself
                            op_q           <= bus.id_ir[15:12];
                            ra_q           <= bus.id_ir[11:9];
`ifdef LCA_LM_BASE_LAST_EN
                            orig_mask      <= bus.id_ir[7:0];
`else
                            offset         <= 3'd1;
`endif
                            mask           <= rem_mask;
                            new_ir_multi_q <= uop;
                            ir_load_mux_q  <= 1'b1;
                            first_q        <= 1'b1;
                            last_q         <= (rem_mask == 8'h00);
                            busy_q         <= 1'b1;
                            state          <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (last_q) begin
                        // Last micro-op has been consumed; release the PC
                        state         <= S_IDLE;
                        ir_load_mux_q <= 1'b0;
                        first_q       <= 1'b0;
                        last_q        <= 1'b0;
                        busy_q        <= 1'b0;
                    end else begin
                        mask           <= rem_mask;
`ifndef LCA_LM_BASE_LAST_EN
                        offset         <= offset + 3'd1;
`endif
                        new_ir_multi_q <= uop;
                        first_q        <= 1'b0;
                        last_q         <= (rem_mask == 8'h00);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A zero-mask LM/SM is dropped by flush request, so fetch need not hold for it
    assign bus.pc_write        = ~((detect && (bus.id_ir[7:0] != 8'h00)) || busy_q);
    assign bus.ir_load_mux     = ir_load_mux_q;
    assign bus.new_ir_multi    = new_ir_multi_q;
    assign bus.first_multiple  = first_q;
    assign bus.last_multiple   = last_q;
    assign bus.busy            = busy_q;
    assign bus.zero_mask_flush = zmf_q;
endmodule
